// File: rtl/retract_stack.sv
// retract_stack: undo-history buffer for the game core.
// Holds up to DEPTH snapshots of the game state in a circular buffer. The most
// recent snapshot is presented combinationally on prev_state. It also keeps a
// saturating step counter and a sticky flag that is set once the oldest history
// has been overwritten.
module retract_stack #(
  parameter int DEPTH   = 8,
  parameter int STATE_W = 134,
  parameter int STEP_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [STATE_W-1:0]       cur_state,
  output logic [STATE_W-1:0]       prev_state,
  output logic                     real_retract,
  output logic [STEP_W-1:0]        step,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     truncated
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]       CNT_ZERO = '0;
  localparam logic [STEP_W-1:0] STEP_MAX = '1;
  localparam logic [STEP_W-1:0] STEP_MIN = '0;

  logic [STATE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      top;
  logic               do_push;
  logic               do_pop;

  // Step counter increment that sticks at the all-ones value.
  function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] s);
    return (s == STEP_MAX) ? s : s + 1'b1;
  endfunction

  // Step counter decrement that sticks at zero.
  function automatic logic [STEP_W-1:0] step_dec(input logic [STEP_W-1:0] s);
    return (s == STEP_MIN) ? s : s - 1'b1;
  endfunction

  // clear wins over everything; a simultaneous push and pop is ignored, and a
  // pop on an empty history does nothing at all.
  assign do_push = push && !pop && !clear;
  assign do_pop  = pop && !push && !clear && (count != CNT_ZERO);

  // The top entry sits one slot behind the write pointer; the subtraction
  // wraps naturally in AW bits.
  assign top = wr_ptr - 1'b1;

  // Snapshot storage: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= cur_state;
    end
  end

  // Control state: pointer, occupancy, step counter and overwrite flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      step      <= '0;
      truncated <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      count     <= '0;
      step      <= '0;
      truncated <= 1'b0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      step   <= step_inc(step);
      if (count == FULL) begin
        truncated <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (do_pop) begin
      wr_ptr <= wr_ptr - 1'b1;
      count  <= count - 1'b1;
      step   <= step_dec(step);
    end
  end

  // Top-of-stack read, masked to zero when no history is held.
  always_comb begin
    prev_state   = '0;
    real_retract = (count != CNT_ZERO);
    if (count != CNT_ZERO) begin
      prev_state = mem[top];
    end
  end

endmodule
